// File: rtl/regfile_wb_pkg.sv
// Shared widths and the buffered write-back entry type for the register file
// write-back arbiter.
package regfile_wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_fifo.sv
// Small synchronous FIFO holding long-latency write-back entries.
// With REGFILE_WB_SQUASH_EN defined, every slot carries an address comparator
// so a younger pipeline write can invalidate older buffered results in place.
module wb_fifo
  import regfile_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
`ifdef REGFILE_WB_SQUASH_EN
  ,
  input  logic                     clr_en,
  input  logic [ADDR_W-1:0]        clr_addr
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == DEPTH_C);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset empties the buffer.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

  // Entry storage; a squashed slot keeps its place and only loses its valid bit.
  always_ff @(posedge clk) begin
`ifdef REGFILE_WB_SQUASH_EN
    if (clr_en) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (mem[i].addr == clr_addr) mem[i].valid <= 1'b0;
      end
    end
`endif
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port. Merges the
// in-order pipeline WB stream with buffered long-latency results, with a
// starvation counter that forces the buffer head out after STARVE_LIMIT
// waiting cycles. Optional WAW squash is enabled by REGFILE_WB_SQUASH_EN.
// Data and address widths come from regfile_wb_pkg.
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int BUF_DEPTH    = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              pipe_valid,
  input  logic [ADDR_W-1:0] pipe_waddr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic              pipe_ready,
  input  logic              lu_valid,
  input  logic [ADDR_W-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              lu_ready,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(BUF_DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0] LIMIT_C = SC_W'(STARVE_LIMIT);

  logic             buf_full;
  logic             buf_empty;
  logic [CNT_W-1:0] buf_count;
  wb_entry_t        head;
  wb_entry_t        push_entry;
  logic             push;
  logic             pop;
  logic             pipe_fire;
  logic             lu_fire;
  logic             lu_squash;
  logic [SC_W-1:0]  starve_cnt;
  logic             starve_hit;

  // Handshakes depend only on registered state so upstream sees no comb loop.
  assign starve_hit = (starve_cnt == LIMIT_C);
  assign pipe_ready = !(buf_full || starve_hit);
  assign lu_ready   = !buf_full;
  assign busy       = (buf_count != '0);

  assign pipe_fire  = pipe_valid && pipe_ready;
  assign lu_fire    = lu_valid && lu_ready;
  assign pop        = !pipe_fire && !buf_empty;

`ifdef REGFILE_WB_SQUASH_EN
  // A same-cycle lu result to the pipeline's destination is already stale.
  assign lu_squash  = pipe_fire && (lu_waddr == pipe_waddr);
`else
  assign lu_squash  = 1'b0;
`endif

  // Results for x0 are consumed but never buffered.
  assign push       = lu_fire && (lu_waddr != '0) && !lu_squash;
  assign push_entry = '{valid: 1'b1, addr: lu_waddr, data: lu_wdata};

  wb_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .resetn     (resetn),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .head       (head),
    .count      (buf_count),
    .full       (buf_full),
    .empty      (buf_empty)
`ifdef REGFILE_WB_SQUASH_EN
    ,
    .clr_en     (pipe_fire && (pipe_waddr != '0)),
    .clr_addr   (pipe_waddr)
`endif
  );

  // Starvation counter: cycles the head waits while the pipeline owns the port.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      starve_cnt <= '0;
    end else if (buf_empty || pop) begin
      starve_cnt <= '0;
    end else if (!starve_hit) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered write port: pipeline wins, else the popped head if still valid.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (pipe_fire) begin
      rf_wen   <= (pipe_waddr != '0);
      rf_waddr <= pipe_waddr;
      rf_wdata <= pipe_wdata;
    end else if (pop) begin
      rf_wen   <= head.valid && (head.addr != '0);
      rf_waddr <= head.addr;
      rf_wdata <= head.data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter (default parameters). Expected values
// are hand-derived; squash expectations follow REGFILE_WB_SQUASH_EN.
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        resetn;
  logic        pipe_valid;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        pipe_ready;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [31:0] shadow_rf [32];

  regfile_wb_arbiter #(
    .BUF_DEPTH    (2),
    .STARVE_LIMIT (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pipe_valid (pipe_valid),
    .pipe_waddr (pipe_waddr),
    .pipe_wdata (pipe_wdata),
    .pipe_ready (pipe_ready),
    .lu_valid   (lu_valid),
    .lu_waddr   (lu_waddr),
    .lu_wdata   (lu_wdata),
    .lu_ready   (lu_ready),
    .rf_wen     (rf_wen),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Architectural register file as seen through the write port.
  always @(posedge clk) begin
    if (rf_wen) shadow_rf[rf_waddr] <= rf_wdata;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    resetn     = 1'b0;
    pipe_valid = 1'b0;
    pipe_waddr = '0;
    pipe_wdata = '0;
    lu_valid   = 1'b0;
    lu_waddr   = '0;
    lu_wdata   = '0;

    // Reset state
    tick();
    tick();
    chk("rst_wen", rf_wen, 0);
    chk("rst_waddr", rf_waddr, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pipe_ready", pipe_ready, 1);
    chk("rst_lu_ready", lu_ready, 1);
    resetn = 1'b1;
    tick();

    // Pipeline write: accepted at edge n, visible in cycle n+1
    pipe_valid = 1'b1; pipe_waddr = 5'd3; pipe_wdata = 32'h1234;
    chk("pipe_ready_pre", pipe_ready, 1);
    tick();
    pipe_valid = 1'b0;
    chk("pipe_wen", rf_wen, 1);
    chk("pipe_waddr", rf_waddr, 3);
    chk("pipe_wdata", rf_wdata, 32'h1234);
    chk("pipe_ready_post", pipe_ready, 1);
    tick();
    chk("pipe_idle_wen", rf_wen, 0);

    // Long-latency write with idle port: busy at n+1, write at n+2
    lu_valid = 1'b1; lu_waddr = 5'd5; lu_wdata = 32'hAA;
    chk("lu_ready_idle", lu_ready, 1);
    tick();
    lu_valid = 1'b0;
    chk("lu_busy", busy, 1);
    chk("lu_no_bypass", rf_wen, 0);
    tick();
    chk("lu_wen", rf_wen, 1);
    chk("lu_waddr", rf_waddr, 5);
    chk("lu_wdata", rf_wdata, 32'hAA);
    chk("lu_busy_clr", busy, 0);
    tick();

    // Starvation: pipeline held busy, one lu entry buffered
    pipe_valid = 1'b1; pipe_waddr = 5'd10; pipe_wdata = 32'h100;
    lu_valid   = 1'b1; lu_waddr   = 5'd9;  lu_wdata   = 32'h99;
    tick();
    lu_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("stv_ready_%0d", k), pipe_ready, 1);
      chk($sformatf("stv_pipe_addr_%0d", k), rf_waddr, 10);
      tick();
    end
    chk("stv_forced", pipe_ready, 0);
    chk("stv_busy", busy, 1);
    tick();
    chk("stv_drain_wen", rf_wen, 1);
    chk("stv_drain_addr", rf_waddr, 9);
    chk("stv_drain_data", rf_wdata, 32'h99);
    chk("stv_resume_ready", pipe_ready, 1);
    chk("stv_busy_clr", busy, 0);
    tick();
    chk("stv_resume_addr", rf_waddr, 10);
    pipe_valid = 1'b0;
    tick();

    // Full buffer
    pipe_valid = 1'b1; pipe_waddr = 5'd11; pipe_wdata = 32'h200;
    lu_valid   = 1'b1; lu_waddr   = 5'd12; lu_wdata   = 32'hC1;
    tick();
    lu_waddr = 5'd13; lu_wdata = 32'hC2;
    chk("full_lu_ready_1", lu_ready, 1);
    tick();
    lu_valid = 1'b0;
    chk("full_lu_ready", lu_ready, 0);
    chk("full_pipe_ready", pipe_ready, 0);
    tick();
    chk("full_pop_addr", rf_waddr, 12);
    chk("full_pop_data", rf_wdata, 32'hC1);
    chk("full_lu_ready_back", lu_ready, 1);
    chk("full_pipe_ready_back", pipe_ready, 1);
    tick();
    chk("full_pipe_addr", rf_waddr, 11);
    pipe_valid = 1'b0;
    tick();
    chk("full_pop2_addr", rf_waddr, 13);
    chk("full_pop2_data", rf_wdata, 32'hC2);
    chk("full_busy_clr", busy, 0);
    tick();

    // WAW ordering on register 7
    lu_valid = 1'b1; lu_waddr = 5'd7; lu_wdata = 32'h11;
    tick();
    lu_valid = 1'b0;
    pipe_valid = 1'b1; pipe_waddr = 5'd7; pipe_wdata = 32'h55;
    tick();
    pipe_valid = 1'b0;
    chk("waw_pipe_wen", rf_wen, 1);
    chk("waw_pipe_data", rf_wdata, 32'h55);
    tick();
`ifdef REGFILE_WB_SQUASH_EN
    chk("waw_pop_wen", rf_wen, 0);
`else
    chk("waw_pop_wen", rf_wen, 1);
    chk("waw_pop_data", rf_wdata, 32'h11);
`endif
    chk("waw_busy", busy, 0);
    tick();
`ifdef REGFILE_WB_SQUASH_EN
    chk("waw_r7", shadow_rf[7], 32'h55);
`else
    chk("waw_r7", shadow_rf[7], 32'h11);
`endif

    // Address 0 on both ports
    pipe_valid = 1'b1; pipe_waddr = 5'd0; pipe_wdata = 32'hDEAD;
    lu_valid   = 1'b1; lu_waddr   = 5'd0; lu_wdata   = 32'hBEEF;
    tick();
    pipe_valid = 1'b0; lu_valid = 1'b0;
    chk("x0_wen", rf_wen, 0);
    chk("x0_busy", busy, 0);
    tick();
    chk("x0_wen_2", rf_wen, 0);
    chk("x0_busy_2", busy, 0);

    // Reset mid-traffic with two buffered entries
    pipe_valid = 1'b1; pipe_waddr = 5'd14; pipe_wdata = 32'h300;
    lu_valid   = 1'b1; lu_waddr   = 5'd15; lu_wdata   = 32'hF1;
    tick();
    lu_waddr = 5'd16; lu_wdata = 32'hF2;
    tick();
    chk("mid_busy", busy, 1);
    chk("mid_lu_ready", lu_ready, 0);
    chk("mid_wen_before", rf_wen, 1);
    resetn = 1'b0; pipe_valid = 1'b0; lu_valid = 1'b0;
    #1;
    chk("mid_rst_wen", rf_wen, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_lu_ready", lu_ready, 1);
    chk("mid_rst_pipe_ready", pipe_ready, 1);
    tick();
    resetn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("mid_after_wen_%0d", k), rf_wen, 0);
      chk($sformatf("mid_after_busy_%0d", k), busy, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
